// File: rtl/branch_resolve_unit_if.sv
// Branch request / resolution bus between decode and the branch resolve unit.
// Purpose: groups the branch handshake, condition inputs, flag status and decision outputs.
// Ports (master = decode/fetch side, slave = branch_resolve_unit):
//   br_valid/br_ready handshake, br_is_reg, ccc, pc_plus2, imm9, reg_target,
//   F {Z,V,N}, flag_pending -> resolve_valid, taken, redirect_pc, flush, timeout.
interface branch_resolve_unit_if;
    logic        br_valid;
    logic        br_ready;
    logic        br_is_reg;
    logic [2:0]  ccc;
    logic [15:0] pc_plus2;
    logic [8:0]  imm9;
    logic [15:0] reg_target;
    logic [2:0]  F;
    logic        flag_pending;
    logic        resolve_valid;
    logic        taken;
    logic [15:0] redirect_pc;
    logic        flush;
    logic        timeout;

    modport master (
        output br_valid, br_is_reg, ccc, pc_plus2, imm9, reg_target, F, flag_pending,
        input  br_ready, resolve_valid, taken, redirect_pc, flush, timeout
    );

    modport slave (
        input  br_valid, br_is_reg, ccc, pc_plus2, imm9, reg_target, F, flag_pending,
        output br_ready, resolve_valid, taken, redirect_pc, flush, timeout
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Purpose: evaluates branch condition codes against flags F={Z,V,N} and redirects fetch.
// Latency: accept -> resolve_valid in 1 cycle, or 1+k cycles after k flag-wait cycles.
// Backpressure: br_ready only in IDLE; br_valid is ignored elsewhere and must be held.
// Ports: clk, rst_n (async active-low), br_if (slave side of branch_resolve_unit_if).
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,   // >= 1, includes the RESOLVE cycle
    parameter int WAIT_MAX     = 4    // >= 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  br_if
);

    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ccc_q, ccc_d;
    logic [15:0]   target_q, target_d;
    logic          taken_q, taken_d;
    logic          timeout_q, timeout_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    logic          accept;
    logic [15:0]   b_target;

    // F[2]=Z, F[1]=V, F[0]=N
    function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'b000:  cond_met = ~z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = ~z & ~n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = z | (~z & ~n);
            3'b101:  cond_met = n | z;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    assign accept   = br_if.br_valid && (state_q == S_IDLE);
    // Sign-extended word offset shifted to bytes; the add wraps modulo 2^16.
    assign b_target = br_if.pc_plus2 + {{6{br_if.imm9[8]}}, br_if.imm9, 1'b0};

    always_comb begin
        state_d     = state_q;
        ccc_d       = ccc_q;
        target_d    = target_q;
        taken_d     = taken_q;
        timeout_d   = timeout_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ccc_d    = br_if.ccc;
                    target_d = br_if.br_is_reg ? br_if.reg_target : b_target;
                    if (br_if.flag_pending) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = S_RESOLVE;
                        taken_d = cond_met(br_if.ccc, br_if.F);
                    end
                end
            end
            S_WAIT: begin
                // The F sampled in the cycle flag_pending falls is already the new value.
                if (!br_if.flag_pending) begin
                    state_d = S_RESOLVE;
                    taken_d = cond_met(ccc_q, br_if.F);
                end else if (wait_cnt_q == WW'(WAIT_MAX - 1)) begin
                    state_d   = S_RESOLVE;
                    taken_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESOLVE: begin
                if (taken_q && (FLUSH_CYCLES > 1)) begin
                    state_d     = S_FLUSH;
                    // RESOLVE already supplied the first flush cycle.
                    flush_cnt_d = FW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ccc_q       <= 3'b000;
            target_q    <= 16'h0000;
            taken_q     <= 1'b0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ccc_q       <= ccc_d;
            target_q    <= target_d;
            taken_q     <= taken_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // All outputs derive from registers, so an async reset clears them at once.
    assign br_if.br_ready      = (state_q == S_IDLE);
    assign br_if.resolve_valid = (state_q == S_RESOLVE);
    assign br_if.taken         = taken_q;
    assign br_if.redirect_pc   = target_q;
    assign br_if.flush         = ((state_q == S_RESOLVE) && taken_q) || (state_q == S_FLUSH);
    assign br_if.timeout       = timeout_q;

endmodule
